// File: rtl/adder8_bist.sv
// Self-test controller for the 8-bit signed adder: drives operands, checks sum/overflow
// against a golden model, and reports pass/fail with the first failing operand pair.
module adder8_bist #(
  parameter int unsigned NUM_RAND      = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic       fail_valid,
  output logic [7:0] fail_a,
  output logic [7:0] fail_b,
  output logic [7:0] dut_a,
  output logic [7:0] dut_b,
  input  logic [7:0] dut_sum,
  input  logic       dut_overflow
);

  localparam int unsigned IDX_W = 9;
  localparam int unsigned CNT_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAND + 7);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [7:0]       dut_a_q, dut_a_d, dut_b_q, dut_b_d;
  logic [7:0]       err_q, err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [7:0]       fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [7:0] exp_sum;
  logic       exp_ovf;
  logic       mismatch;

  // Fixed directed corner-case operands, {a, b}.
  function automatic logic [15:0] directed_vec(input logic [2:0] i);
    case (i)
      3'd0:    return 16'h0A14;
      3'd1:    return 16'h7F01;
      3'd2:    return 16'hF60A;
      3'd3:    return 16'h0000;
      3'd4:    return 16'h7F7F;
      3'd5:    return 16'h80FF;
      3'd6:    return 16'h8080;
      default: return 16'hFF01;
    endcase
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  assign exp_sum  = dut_a_q + dut_b_q;
  assign exp_ovf  = (dut_a_q[7] == dut_b_q[7]) && (exp_sum[7] != dut_a_q[7]);
  assign mismatch = (dut_sum != exp_sum) || (dut_overflow != exp_ovf);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    lfsr_d       = lfsr_q;
    dut_a_d      = dut_a_q;
    dut_b_d      = dut_b_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;
    busy_d       = busy_q;
    done_d       = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d              = 8'd0;
          fail_valid_d       = 1'b0;
          fail_a_d           = 8'd0;
          fail_b_d           = 8'd0;
          idx_d              = '0;
          lfsr_d             = LFSR_SEED;
          {dut_a_d, dut_b_d} = directed_vec(3'd0);
          busy_d             = 1'b1;
          done_d             = 1'b0;
          state_d            = S_DRIVE;
        end
      end
      S_DRIVE: begin
        cnt_d   = CNT_W'(SETTLE_CYCLES);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_a_d     = dut_a_q;
            fail_b_d     = dut_b_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q < IDX_W'(7)) begin
            {dut_a_d, dut_b_d} = directed_vec(3'(idx_q + IDX_W'(1)));
          end else begin
            {dut_a_d, dut_b_d} = lfsr_q;
            lfsr_d             = lfsr_step(lfsr_q);
          end
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      dut_a_q      <= 8'd0;
      dut_b_q      <= 8'd0;
      err_q        <= 8'd0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= 8'd0;
      fail_b_q     <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      dut_a_q      <= dut_a_d;
      dut_b_q      <= dut_b_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = done_q && (err_q == 8'd0);
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign dut_a      = dut_a_q;
  assign dut_b      = dut_b_q;

endmodule

// File: tb/tb_adder8_bist.sv
// Directed bench for adder8_bist: behavioural adder with injectable faults beside two
// controller instances (default parameters, and NUM_RAND=0 / SETTLE_CYCLES=3).
module tb_adder8_bist;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       ovf;
  } vec_t;

  vec_t vtab [8];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, start2 = 1'b0;
  logic [1:0] fault = 2'd0;

  logic       busy, done, pass, fail_valid;
  logic [7:0] err_count, fail_a, fail_b, dut_a, dut_b, m_sum;
  logic       m_ovf;
  logic       busy2, done2, pass2, fail_valid2;
  logic [7:0] err_count2, fail_a2, fail_b2, dut_a2, dut_b2, m_sum2;
  logic       m_ovf2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Adder under test; fault 1 = sum[0] stuck at 0, fault 2 = overflow stuck at 0.
  always_comb begin
    m_sum = dut_a + dut_b;
    m_ovf = (dut_a[7] == dut_b[7]) && (m_sum[7] != dut_a[7]);
    if (fault == 2'd1) m_sum[0] = 1'b0;
    if (fault == 2'd2) m_ovf = 1'b0;
  end

  always_comb begin
    m_sum2 = dut_a2 + dut_b2;
    m_ovf2 = (dut_a2[7] == dut_b2[7]) && (m_sum2[7] != dut_a2[7]);
  end

  adder8_bist u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b),
    .dut_a(dut_a), .dut_b(dut_b), .dut_sum(m_sum), .dut_overflow(m_ovf)
  );

  adder8_bist #(.NUM_RAND(0), .LFSR_SEED(16'hACE1), .SETTLE_CYCLES(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .fail_valid(fail_valid2), .fail_a(fail_a2), .fail_b(fail_b2),
    .dut_a(dut_a2), .dut_b(dut_b2), .dut_sum(m_sum2), .dut_overflow(m_ovf2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected mismatch count for the default 8 + 64 vector run under a given fault.
  function automatic int exp_errs(input int f);
    int n = 0;
    logic [15:0] l = 16'hACE1;
    logic [7:0] a, b, s;
    logic o;
    for (int i = 0; i < 8; i++) begin
      if (f == 1 && vtab[i].sum[0]) n++;
      if (f == 2 && vtab[i].ovf) n++;
    end
    for (int i = 0; i < 64; i++) begin
      a = l[15:8];
      b = l[7:0];
      s = a + b;
      o = (a[7] == b[7]) && (s[7] != a[7]);
      if (f == 1 && s[0]) n++;
      if (f == 2 && o) n++;
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    end
    return n;
  endfunction

  // One run of the default instance: start at edge 0, optional extra start pulse at busy_pulse_at.
  task automatic do_run(input int busy_pulse_at, output int done_edge, output int busy_cycles);
    int e;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", int'(busy), 1);
    check("start_done_clr", int'(done), 0);
    check("start_err_clr", int'(err_count), 0);
    check("start_fv_clr", int'(fail_valid), 0);
    e = 0;
    done_edge = -1;
    busy_cycles = 0;
    while (e < 400) begin
      if (done) begin
        done_edge = e;
        break;
      end
      if (busy) busy_cycles++;
      if (e % 3 == 0 && e / 3 < 8) begin
        check($sformatf("vec%0d_a", e / 3), int'(dut_a), int'(vtab[e / 3].a));
        check($sformatf("vec%0d_b", e / 3), int'(dut_b), int'(vtab[e / 3].b));
      end
      if (e == 24) check("lfsr_vec8", int'({dut_a, dut_b}), 32'hACE1);
      if (e == 27) check("lfsr_vec9", int'({dut_a, dut_b}), 32'h5670);
      if (e + 1 == busy_pulse_at) start = 1'b1;
      tick();
      start = 1'b0;
      e++;
    end
    check("done_edge", done_edge, 216);
    check("busy_low_at_done", int'(busy), 0);
  endtask

  int de, bc, err_f1, changes, e2;
  logic [7:0] prev_a;

  initial begin
    vtab[0] = '{8'h0A, 8'h14, 8'h1E, 1'b0};
    vtab[1] = '{8'h7F, 8'h01, 8'h80, 1'b1};
    vtab[2] = '{8'hF6, 8'h0A, 8'h00, 1'b0};
    vtab[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vtab[4] = '{8'h7F, 8'h7F, 8'hFE, 1'b1};
    vtab[5] = '{8'h80, 8'hFF, 8'h7F, 1'b1};
    vtab[6] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vtab[7] = '{8'hFF, 8'h01, 8'h00, 1'b0};

    // Reset state
    tick();
    tick();
    check("rst_outputs", int'({busy, done, pass, fail_valid, err_count, fail_a, fail_b, dut_a, dut_b}), 0);
    rst_n = 1'b1;
    tick();
    check("idle_no_start", int'({busy, done}), 0);

    // Correct adder, run from IDLE
    fault = 2'd0;
    do_run(0, de, bc);
    check("good_busy_cycles", bc, 216);
    check("good_pass", int'(pass), 1);
    check("good_err", int'(err_count), 0);
    check("good_fv", int'(fail_valid), 0);

    // sum[0] stuck at 0, restarted from DONE
    fault = 2'd1;
    do_run(0, de, bc);
    err_f1 = int'(err_count);
    check("f1_err", err_f1, exp_errs(1));
    check("f1_err_ge1", int'(err_f1 >= 1), 1);
    check("f1_fail_a", int'(fail_a), 8'h80);
    check("f1_fail_b", int'(fail_b), 8'hFF);
    check("f1_fv", int'(fail_valid), 1);
    check("f1_pass", int'(pass), 0);
    for (int i = 0; i < 5; i++) tick();
    check("done_hold", int'({done, busy, err_count}), int'({1'b1, 1'b0, 8'(err_f1)}));

    // start pulsed mid-run must not disturb timing or results
    do_run(100, de, bc);
    check("busy_start_busy_cycles", bc, 216);
    check("busy_start_err", int'(err_count), err_f1);
    check("busy_start_fail_ab", int'({fail_a, fail_b}), 32'h80FF);

    // overflow stuck at 0
    fault = 2'd2;
    do_run(0, de, bc);
    check("f2_err", int'(err_count), exp_errs(2));
    check("f2_err_ge4", int'(err_count >= 8'd4), 1);
    check("f2_fail_a", int'(fail_a), 8'h7F);
    check("f2_fail_b", int'(fail_b), 8'h01);
    check("f2_pass", int'(pass), 0);

    // Reset at cycle 50 of a run, then a clean rerun
    fault = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 50; i++) tick();
    check("pre_rst_fv", int'(fail_valid), 1);
    rst_n = 1'b0;
    tick();
    check("midrst_outputs", int'({busy, done, pass, fail_valid, err_count, fail_a, fail_b, dut_a, dut_b}), 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("midrst_idle", int'({busy, done}), 0);
    do_run(0, de, bc);
    check("midrst_err", int'(err_count), err_f1);
    check("midrst_fail_ab", int'({fail_a, fail_b}), 32'h80FF);

    // NUM_RAND=0, SETTLE_CYCLES=3 instance
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("d2_busy", int'(busy2), 1);
    e2 = 0;
    changes = 0;
    prev_a = dut_a2;
    while (e2 < 200 && !done2) begin
      if (e2 % 5 == 0 && e2 / 5 < 8)
        check($sformatf("d2_vec%0d", e2 / 5), int'({dut_a2, dut_b2}), int'({vtab[e2 / 5].a, vtab[e2 / 5].b}));
      else if (dut_a2 != prev_a)
        changes++;
      prev_a = dut_a2;
      tick();
      e2++;
    end
    check("d2_done_edge", e2, 40);
    check("d2_hold_5", changes, 0);
    check("d2_pass", int'({done2, pass2, busy2, fail_valid2}), 4'b1100);
    check("d2_err", int'(err_count2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder8_bist.md
# adder8_bist

Built-in self-test controller for the 8-bit signed adder with overflow flag (`adder8`). It sits beside the adder and drives its `a` and `b` inputs. It checks the adder's `sum` and `overflow` outputs against an internal golden model and reports pass/fail and error statistics. Vectors come from a fixed directed corner-case list, then an LFSR-driven random phase, so the same coverage is available in silicon and in simulation.

## Interface
Parameters:
- `NUM_RAND`, 64: number of pseudo-random vectors after the directed list; 0 to 255.
- `LFSR_SEED`, 16'hACE1: LFSR load value at each start; must be nonzero.
- `SETTLE_CYCLES`, 1: wait cycles between driving a vector and sampling the result; 1 to 15.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  single-cycle request, sampled only in IDLE or DONE.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE.
- `done`  out  1  high in DONE, held until the next start or reset.
- `pass`  out  1  equals `done` && (`err_count` == 0).
- `err_count`  out  8  mismatching vectors; saturates at 255.
- `fail_valid`  out  1  set on the first mismatch of a run.
- `fail_a`, `fail_b`  out  8 each  operands of the first mismatch; valid while `fail_valid`.
- `dut_a`, `dut_b`  out  8 each  registered operands to the adder.
- `dut_sum`  in  8  adder sum.
- `dut_overflow`  in  1  adder overflow.

## Operation
- Golden model:
  - exp_sum = (a+b) mod 256.
  - exp_ovf = (a[7]==b[7]) && (exp_sum[7]!=a[7]), i.e. two's-complement overflow.
- A mismatch is any difference in `sum` or `overflow`.
- Directed vectors, indices 0 to 7, as a,b -> sum,ovf:
  - 0x0A,0x14 -> 0x1E,0
  - 0x7F,0x01 -> 0x80,1
  - 0xF6,0x0A -> 0x00,0
  - 0x00,0x00 -> 0x00,0
  - 0x7F,0x7F -> 0xFE,1
  - 0x80,0xFF -> 0x7F,1
  - 0x80,0x80 -> 0x00,1
  - 0xFF,0x01 -> 0x00,0
- Random vectors, indices 8 to 8+NUM_RAND-1:
  - LFSR is Fibonacci, 16-bit, taps 16,14,13,11.
  - a = lfsr[15:8], b = lfsr[7:0].
  - LFSR advances once per random vector, after it is driven.
  - LFSR is reloaded with `LFSR_SEED` on every accepted start.
- FSM states:
  - IDLE: on `start`, clear `err_count`, `fail_valid`, `fail_a`, `fail_b`; set idx=0; load LFSR; go to DRIVE.
  - DRIVE: `dut_a` and `dut_b` already hold vector idx; go to SETTLE with wait counter = SETTLE_CYCLES.
  - SETTLE: decrement the counter; go to CHECK when it expires.
  - CHECK: compare `dut_sum` and `dut_overflow` against the model. On mismatch, increment `err_count` (saturating). On the first mismatch, capture `fail_a`/`fail_b` and set `fail_valid`. If idx is last, go to DONE; else increment idx, load the next vector into `dut_a`/`dut_b`, and go to DRIVE.
  - DONE: `done`=1 and `busy`=0. A `start` here behaves as in IDLE and restarts the run.
- `start` is ignored while `busy`.
- Results stay stable in DONE until restart or reset.

## Timing
- Reset values: all outputs 0, including `dut_a` and `dut_b`; state IDLE; LFSR = `LFSR_SEED`.
- Reset mid-run aborts to IDLE within one edge. No partial results are retained.
- `dut_a`/`dut_b` change only on the edge entering DRIVE and are stable through DRIVE, SETTLE and CHECK.
- Per-vector cost is SETTLE_CYCLES+2 cycles.
- Take the edge that accepts `start` as edge 0. `done` rises at edge (8+NUM_RAND)*(SETTLE_CYCLES+2). For the defaults that is edge 216.
- `busy` rises at edge 0 and falls at the same edge `done` rises.
- `err_count` updates at the edge leaving CHECK.
- `pass` is combinational from `done` and `err_count`.

## Test plan
- Correct adder8 model, default parameters, pulse `start` -> `busy` for 216 cycles, then `done`=1, `pass`=1, `err_count`=0, `fail_valid`=0.
- Fault model with `sum[0]` stuck at 0 -> first failure is vector 5: `fail_a`=0x80, `fail_b`=0xFF, `fail_valid`=1, `pass`=0, `err_count`≥1.
- Fault model with `overflow` stuck at 0 -> first failure is vector 1: `fail_a`=0x7F, `fail_b`=0x01. At least 4 directed errors are counted.
- `rst_n` low at cycle 50 of a run -> next edge all outputs 0 and state IDLE. A new `start` then completes in 216 cycles with results identical to an uninterrupted run.
- `start` pulsed while `busy` -> no effect on timing or results. `start` pulsed in DONE -> restart with counters cleared and an identical `err_count` (LFSR reseeded).
- `NUM_RAND`=0, `SETTLE_CYCLES`=3 -> `done` at edge 40; only directed vectors are applied, and each `dut_a` value is held for 5 cycles.
